sm4_round_ctrl: RTL and testbench

SM4_ROUND_CTRL -- requirements
Module: sm4_round_ctrl

---
 rtl/sm4_pkg.sv | 51 +++++
 rtl/sm4_t_func.sv | 25 ++
 rtl/sm4_xor_tree.sv | 18 +
 rtl/sm4_round_ctrl.sv | 115 +++++++++++
 tb/tb_sm4_round_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm4_pkg.sv
// SM4 shared types, FSM states and the S-box table.
// Imported by the round controller and its T mixer.
package sm4_pkg;

  localparam int SM4_ROUNDS = 32;

  typedef logic [31:0] sm4_word_t;
  typedef sm4_word_t [3:0] sm4_block_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sm4_state_t;

  localparam logic [7:0] SM4_SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7,
    8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3,
    8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a,
    8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95,
    8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba,
    8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b,
    8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2,
    8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52,
    8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5,
    8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55,
    8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60,
    8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f,
    8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f,
    8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd,
    8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e,
    8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20,
    8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

endpackage

// File: rtl/sm4_t_func.sv
// SM4 round mixer T: four S-boxes then linear L.
// Ports: x (32-bit word in), y (T(x) out).
module sm4_t_func
  import sm4_pkg::*;
(
  input  sm4_word_t x,
  output sm4_word_t y
);

  sm4_word_t b;

  always_comb begin
    b = '0;
    for (int k = 0; k < 4; k++) begin
      b[8*k +: 8] = SM4_SBOX[x[8*k +: 8]];
    end
  end

  assign y = b
           ^ {b[29:0], b[31:30]}
           ^ {b[21:0], b[31:22]}
           ^ {b[13:0], b[31:14]}
           ^ {b[7:0],  b[31:8]};

endmodule

// File: rtl/sm4_xor_tree.sv
// Generic N-input XOR reduction of W-bit words.
// Ports: a (N packed words in), y (XOR of all words).
module sm4_xor_tree #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic [N-1:0][W-1:0] a,
  output logic [W-1:0]        y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) begin
      y = y ^ a[i];
    end
  end

endmodule

// File: rtl/sm4_round_ctrl.sv
// Iterative SM4 block engine: one round per cycle.
// Ports: block in (data_i/decrypt_i/v_i/ready_o),
// round-key read (key_ready_i/rk_addr_o/rk_i),
// result out (data_o/v_o/ready_i), busy_o.
module sm4_round_ctrl
  import sm4_pkg::*;
#(
  parameter int rounds_p = SM4_ROUNDS
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  sm4_block_t data_i,
  input  logic       decrypt_i,
  input  logic       v_i,
  output logic       ready_o,
  input  logic       key_ready_i,
  output logic [4:0] rk_addr_o,
  input  sm4_word_t  rk_i,
  output sm4_block_t data_o,
  output logic       v_o,
  input  logic       ready_i,
  output logic       busy_o
);

  localparam logic [4:0] LAST = 5'(rounds_p - 1);

  sm4_state_t state;
  sm4_state_t state_nxt;
  logic [4:0] r;
  sm4_block_t x;
  logic       mode;

  logic       accept;
  logic       last;
  sm4_word_t  mix;
  sm4_word_t  t_out;
  sm4_word_t  xnew;
  logic [3:0][31:0] mix_in;

  assign accept = v_i & ready_o;
  assign last   = (r == LAST);
  assign mix_in = {x[1], x[2], x[3], rk_i};

  sm4_xor_tree #(
    .N (4),
    .W (32)
  ) u_xor (
    .a (mix_in),
    .y (mix)
  );

  sm4_t_func u_t (
    .x (mix),
    .y (t_out)
  );

  assign xnew = x[0] ^ t_out;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      r     <= '0;
      x     <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (accept) begin
            x    <= data_i;
            mode <= decrypt_i;
            r    <= '0;
          end
        end
        RUN: begin
          x <= {xnew, x[3], x[2], x[1]};
          // Hold r on the final round; no wrap.
          if (!last) begin
            r <= r + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)  state_nxt = RUN;
      RUN:  if (last)    state_nxt = DONE;
      DONE: if (ready_i) state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_o   = (state == IDLE) & key_ready_i;
    busy_o    = (state != IDLE);
    v_o       = 1'b0;
    data_o    = '0;
    rk_addr_o = '0;
    if (state == RUN) begin
      rk_addr_o = mode ? (LAST - r) : r;
    end
    if (state == DONE) begin
      v_o       = 1'b1;
      data_o[0] = x[3];
      data_o[1] = x[2];
      data_o[2] = x[1];
      data_o[3] = x[0];
    end
  end

endmodule

// File: tb/tb_sm4_round_ctrl.sv
// Randomized self-checking bench for sm4_round_ctrl.
// Block-level SM4 reference plus cycle scoreboard.
module tb_sm4_round_ctrl;
  import sm4_pkg::*;

  localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  sm4_block_t data_i;
  logic       decrypt_i;
  logic       v_i;
  logic       ready_o;
  logic       key_ready_i;
  logic [4:0] rk_addr_o;
  sm4_word_t  rk_i;
  sm4_block_t data_o;
  logic       v_o;
  logic       ready_i;
  logic       busy_o;

  logic [31:0] rk_rom [32];
  int pass_n = 0;
  int total_n = 0;

  assign rk_i = rk_rom[rk_addr_o];

  always #5 clk_i = ~clk_i;

  sm4_round_ctrl dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .data_i      (data_i),
    .decrypt_i   (decrypt_i),
    .v_i         (v_i),
    .ready_o     (ready_o),
    .key_ready_i (key_ready_i),
    .rk_addr_o   (rk_addr_o),
    .rk_i        (rk_i),
    .data_o      (data_o),
    .v_o         (v_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o)
  );

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] w,
                                       input int n);
    return (w << n) | (w >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] w);
    logic [31:0] b;
    for (int k = 0; k < 4; k++) b[8*k +: 8] = SM4_SBOX[w[8*k +: 8]];
    return b;
  endfunction

  function automatic logic [31:0] t_enc(input logic [31:0] w);
    logic [31:0] b;
    b = tau(w);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] w);
    logic [31:0] b;
    b = tau(w);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  // Word 0 of a block is the most significant 32 bits of the value.
  function automatic sm4_block_t mk(input logic [127:0] v);
    sm4_block_t b;
    for (int i = 0; i < 4; i++) b[i] = v[127-32*i -: 32];
    return b;
  endfunction

  task automatic key_sched(input logic [127:0] key);
    logic [31:0] k [36];
    logic [31:0] fk [4];
    logic [31:0] ck;
    fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
    for (int i = 0; i < 4; i++) k[i] = key[127-32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      ck = '0;
      for (int j = 0; j < 4; j++)
        ck = (ck << 8) | 32'(((4 * i + j) * 7) % 256);
      k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      rk_rom[i] = k[i+4];
    end
  endtask

  function automatic sm4_block_t sm4_ref(input sm4_block_t in,
                                         input logic dec);
    logic [31:0] xs [36];
    sm4_block_t o;
    for (int i = 0; i < 4; i++) xs[i] = in[i];
    for (int i = 0; i < 32; i++)
      xs[i+4] = xs[i] ^ t_enc(xs[i+1] ^ xs[i+2] ^ xs[i+3]
                               ^ rk_rom[dec ? 31 - i : i]);
    for (int i = 0; i < 4; i++) o[i] = xs[35-i];
    return o;
  endfunction

  // Cycle-level expectation: age = cycles since accept, -1 when idle.
  int         age = -1;
  sm4_block_t m_res;
  logic       m_dec;

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      age = -1;
    end else if (age < 0) begin
      if (v_i && key_ready_i) begin
        age   = 0;
        m_dec = decrypt_i;
        m_res = sm4_ref(data_i, decrypt_i);
      end
    end else if (age < SM4_ROUNDS) begin
      age++;
    end else if (ready_i) begin
      age = -1;
    end
  end

  always @(negedge clk_i) begin
    logic       e_v;
    sm4_block_t e_d;
    logic [4:0] e_rk;
    e_v  = (age == SM4_ROUNDS);
    e_d  = e_v ? m_res : '0;
    e_rk = '0;
    if (age >= 0 && age < SM4_ROUNDS)
      e_rk = 5'(m_dec ? SM4_ROUNDS - 1 - age : age);
    chk("cyc_ready", 128'(ready_o), 128'(age < 0 && key_ready_i));
    chk("cyc_busy", 128'(busy_o), 128'(age >= 0));
    chk("cyc_v", 128'(v_o), 128'(e_v));
    chk("cyc_rk_addr", 128'(rk_addr_o), 128'(e_rk));
    chk("cyc_data", data_o, e_d);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [4:0] rk_seq [$];

  task automatic send(input sm4_block_t b, input logic dec,
                      output int lat);
    int n;
    data_i = b;
    decrypt_i = dec;
    v_i = 1'b1;
    n = 0;
    while (!ready_o && n < 100) begin
      tick();
      n++;
    end
    if (!ready_o) chk("accept_timeout", 128'(ready_o), 128'(1));
    tick();
    v_i = 1'b0;
    rk_seq.delete();
    lat = 0;
    while (!v_o && lat < 100) begin
      rk_seq.push_back(rk_addr_o);
      tick();
      lat++;
    end
  endtask

  initial begin
    int         lat;
    int         seen;
    int         cyc;
    int         prev;
    int         nres;
    logic       acc;
    logic       hs;
    sm4_block_t snap;
    sm4_block_t blk;
    sm4_block_t exp_q [$];

    reset_n_i = 1'b0;
    v_i = 1'b0;
    decrypt_i = 1'b0;
    key_ready_i = 1'b0;
    ready_i = 1'b1;
    data_i = '0;
    key_sched(PT);

    chk("rk0_literal", 128'(rk_rom[0]), 128'h f12186f9);
    chk("rk31_literal", 128'(rk_rom[31]), 128'h9124a012);
    chk("ref_enc", sm4_ref(mk(PT), 1'b0), mk(CT));
    chk("ref_dec", sm4_ref(mk(CT), 1'b1), mk(PT));

    repeat (3) tick();
    chk("rst_v", 128'(v_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_data", data_o, '0);
    chk("rst_rk", 128'(rk_addr_o), 128'(0));
    key_ready_i = 1'b1;
    reset_n_i = 1'b1;
    #1;
    chk("ready_after_release", 128'(ready_o), 128'(1));
    tick();

    send(mk(PT), 1'b0, lat);
    chk("enc_latency", 128'(lat), 128'(32));
    chk("enc_data", data_o, mk(CT));
    ready_i = 1'b0;
    snap = data_o;
    repeat (10) begin
      tick();
      chk("hold_v", 128'(v_o), 128'(1));
      chk("hold_data", data_o, snap);
      chk("hold_ready", 128'(ready_o), 128'(0));
    end
    ready_i = 1'b1;
    tick();

    send(mk(CT), 1'b1, lat);
    chk("dec_latency", 128'(lat), 128'(32));
    chk("dec_data", data_o, mk(PT));
    chk("dec_seq_len", 128'(rk_seq.size()), 128'(32));
    for (int i = 0; i < rk_seq.size() && i < 32; i++)
      chk("dec_rk_seq", 128'(rk_seq[i]), 128'(31 - i));
    tick();

    // Reset in the middle of a block.
    data_i = mk({$urandom, $urandom, $urandom, $urandom});
    decrypt_i = 1'b0;
    v_i = 1'b1;
    tick();
    v_i = 1'b0;
    repeat (15) tick();
    chk("mid_rk15", 128'(rk_addr_o), 128'(15));
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_v", 128'(v_o), 128'(0));
    chk("mid_rst_busy", 128'(busy_o), 128'(0));
    chk("mid_rst_data", data_o, '0);
    chk("mid_rst_rk", 128'(rk_addr_o), 128'(0));
    tick();
    tick();
    reset_n_i = 1'b1;
    seen = 0;
    repeat (40) begin
      tick();
      if (v_o) seen++;
    end
    chk("no_v_after_reset", 128'(seen), 128'(0));

    // Accept gating by key_ready_i.
    key_ready_i = 1'b0;
    blk = mk({$urandom, $urandom, $urandom, $urandom});
    data_i = blk;
    decrypt_i = 1'b1;
    v_i = 1'b1;
    repeat (5) begin
      tick();
      chk("gate_busy", 128'(busy_o), 128'(0));
      chk("gate_ready", 128'(ready_o), 128'(0));
    end
    key_ready_i = 1'b1;
    #1;
    chk("gate_open", 128'(ready_o), 128'(1));
    tick();
    v_i = 1'b0;
    chk("gate_accepted", 128'(busy_o), 128'(1));
    key_ready_i = 1'b0;
    lat = 0;
    while (!v_o && lat < 100) begin
      tick();
      lat++;
    end
    chk("keydrop_no_abort", 128'(v_o), 128'(1));
    chk("keydrop_data", data_o, sm4_ref(blk, 1'b1));
    key_ready_i = 1'b1;
    tick();

    // Back-to-back blocks.
    ready_i = 1'b1;
    v_i = 1'b1;
    data_i = mk({$urandom, $urandom, $urandom, $urandom});
    decrypt_i = 1'($urandom_range(0, 1));
    cyc = 0;
    prev = -1;
    nres = 0;
    while (nres < 5 && cyc < 400) begin
      acc = v_i && ready_o;
      hs = v_o && ready_i;
      if (hs) begin
        chk("b2b_data", data_o, exp_q.pop_front());
        nres++;
      end
      if (acc) exp_q.push_back(sm4_ref(data_i, decrypt_i));
      tick();
      cyc++;
      if (acc) begin
        if (prev >= 0) chk("b2b_spacing", 128'(cyc - prev), 128'(34));
        prev = cyc;
        data_i = mk({$urandom, $urandom, $urandom, $urandom});
        decrypt_i = 1'($urandom_range(0, 1));
      end
    end
    chk("b2b_count", 128'(nres), 128'(5));
    v_i = 1'b0;

    // Random traffic; the cycle scoreboard does the checking.
    repeat (3000) begin
      v_i = ($urandom_range(0, 1) == 1);
      ready_i = ($urandom_range(0, 9) < 7);
      key_ready_i = ($urandom_range(0, 19) < 17);
      decrypt_i = 1'($urandom_range(0, 1));
      data_i = mk({$urandom, $urandom, $urandom, $urandom});
      reset_n_i = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset_n_i = 1'b1;
    v_i = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
